dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Sits between the data memory and two requesters: port 0 is the core load/store path and port 1 is the debug/DMA path.
- Grants at most one access per cycle using round-robin arbitration and returns read data one cycle later, registered.
- Owns a clear sequencer that zeroes every word of the memory, either after reset or on command.
- The memory it drives has a combinational read and a synchronous write, both word-addressed by addr[31:2].

Parameters:
- DEPTH, 256, number of 32-bit words in the data memory; must be a power of two.
- CLEAR_ON_RESET, 1, when 1 the block enters ST_CLEAR on reset; when 0 it enters ST_SERVE.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_start  in  1  one-cycle request to start a full clear.
- clr_busy  out  1  high while the clear sequencer owns the memory.
- m0_req  in  1  port 0 access request.
- m0_we  in  1  port 0 write enable (1 = write, 0 = read).
- m0_addr  in  32  port 0 byte address; bits [1:0] are ignored.
- m0_wdata  in  32  port 0 write data.
- m0_gnt  out  1  port 0 access issued this cycle (combinational).
- m0_rvalid  out  1  port 0 read data valid (registered).
- m0_rdata  out  32  port 0 read data (registered).
- m0_err  out  1  port 0 out-of-range access (registered, one-cycle pulse).
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as port 0, for port 1.
- mem_we  out  1  write enable to the memory.
- mem_a  out  32  byte address to the memory.
- mem_wd  out  32  write data to the memory.
- mem_rd  in  32  combinational read data from the memory.

Behaviour:
- Reset (asynchronous, rst=1):
  - state = ST_CLEAR if CLEAR_ON_RESET, else ST_SERVE.
  - clr_cnt = 0; last_gnt = 1, so port 0 wins the first contention.
  - All rvalid, rdata and err outputs = 0.
  - clr_busy = CLEAR_ON_RESET.
- Reset asserted mid-clear abandons the clear. The clear restarts from word 0 only if CLEAR_ON_RESET=1.
- ST_CLEAR:
  - mem_we=1, mem_a={clr_cnt,2'b00}, mem_wd=0; gnt outputs are 0.
  - clr_cnt increments every cycle.
  - On the cycle clr_cnt==DEPTH-1 the write still occurs; next state is ST_SERVE and clr_cnt returns to 0.
  - The clear takes exactly DEPTH cycles. clr_start is ignored during a clear.
  - Requests made during a clear are held pending and are not dropped.
- ST_SERVE:
  - clr_start=1 moves to ST_CLEAR next cycle. No grant is issued in the cycle clr_start is sampled; clear priority beats requests.
  - Otherwise, with only one req high, that port is granted.
  - With both req high, the port != last_gnt is granted, and last_gnt updates at the edge on every grant.
  - Granted port drives mem_a=addr and mem_wd=wdata.
  - mem_we=we, unless the access is out of range.
  - With no grant: mem_we=0, mem_a=0, mem_wd=0.
- Range: out of range means addr[31:2] >= DEPTH.
  - The access is still granted, the write is suppressed, and read data = 0.
  - mX_err pulses for one cycle, aligned with where rvalid would be.
  - rvalid also pulses for an out-of-range read.
- Read latency:
  - The cycle after a read grant: mX_rvalid=1 and mX_rdata = mem_rd sampled at the grant edge.
  - rdata holds its value until the next read completion on that port.
  - rvalid is 0 after a write grant.
- Write timing: a write commits at the grant edge.
  - A read granted the following cycle to the same address returns the new data.
  - There is no same-cycle read/write conflict, because there is only one access per cycle.
- Requester contract: req, we, addr and wdata stay stable until gnt. Deasserting req before gnt withdraws the request with no side effect.
- Back-to-back: a port holding req high while the other is idle is granted every cycle, giving full throughput.

Decomposition:
- Package dmem_pkg: state enum {ST_SERVE, ST_CLEAR}; WORD_W=32; function word_idx(addr) returning addr[31:2].
- One sub-module, rr_arb2: a 2-requester round-robin arbiter holding last_gnt, with inputs req[1:0] and en, and output gnt[1:0].

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=256, release rst: clr_busy is high for exactly 256 cycles, mem_we=1, mem_a steps 0x000..0x3FC, and mem_wd=0. A read of 0x40 afterwards returns 0.
- Port 0 writes 0xDEADBEEF to 0x10, then reads 0x10: m0_gnt=1 on both cycles, and one cycle after the read grant m0_rvalid=1 with m0_rdata=0xDEADBEEF.
- Both ports continuously request after reset: the grant sequence is 0,1,0,1. Port 1 write 0x1 to 0x20 and port 0 read 0x20 are both granted in sequence, with no double grant in any cycle.
- Port 1 reads 0x400 (word 256): granted; the next cycle gives m1_err=1, m1_rvalid=1, m1_rdata=0. Port 1 then writes 0x400 with 0x55: mem_we stays 0 and m1_err pulses.
- clr_start pulses while port 0 is requesting: no grant occurs for DEPTH+1 cycles, then the pending port 0 request is granted. A second clr_start during the clear changes nothing.
- Assert rst when clr_cnt=100: all outputs return to reset values immediately, and the clear restarts at word 0 after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter slice.
package dmem_pkg;

  typedef enum logic {
    ST_SERVE = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int WORD_W = 32;

  function automatic logic [29:0] word_idx(input logic [WORD_W-1:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the port that did not win last time wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_gnt_r;

  // Pick at most one requester, favouring the one not granted last.
  always_comb begin
    gnt = 2'b00;
    if (!en) begin
      gnt = 2'b00;
    end else if (req == 2'b11) begin
      gnt = last_gnt_r ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Remember the most recent winner; port 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_r <= 1'b1;
    end else if (gnt != 2'b00) begin
      last_gnt_r <= gnt[1];
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory front end: round-robin access for two ports, registered read
// return, and a sequencer that zeroes the whole memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [WORD_W-1:0] m0_addr,
  input  logic [WORD_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [WORD_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [WORD_W-1:0] m1_addr,
  input  logic [WORD_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [WORD_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_a,
  output logic [WORD_W-1:0] mem_wd,
  input  logic [WORD_W-1:0] mem_rd
);

  localparam int AW = $clog2(DEPTH);

  state_t            state_r;
  logic [AW-1:0]     clr_cnt_r;
  logic [1:0]        gnt_s;
  logic              arb_en_s;
  logic              any_s;
  logic              we_s;
  logic              oor_s;
  logic [WORD_W-1:0] addr_s;
  logic [WORD_W-1:0] wdata_s;
  logic [1:0]        rvalid_r;
  logic [1:0]        err_r;
  logic [WORD_W-1:0] rdata_r [2];

  // A pending clr_start takes the cycle, so no grant is issued alongside it.
  assign arb_en_s = (state_r == ST_SERVE) && !clr_start;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({m1_req, m0_req}),
    .en  (arb_en_s),
    .gnt (gnt_s)
  );

  // Steer the winning port's request onto shared signals.
  always_comb begin
    any_s   = |gnt_s;
    addr_s  = gnt_s[1] ? m1_addr  : m0_addr;
    wdata_s = gnt_s[1] ? m1_wdata : m0_wdata;
    we_s    = gnt_s[1] ? m1_we    : m0_we;
    oor_s   = word_idx(addr_s) >= 30'(DEPTH);
  end

  // Memory port: clear writes own it, otherwise the granted access drives it.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = 32'h0000_0000;
    mem_wd = 32'h0000_0000;
    if (state_r == ST_CLEAR) begin
      mem_we = 1'b1;
      mem_a  = 32'({clr_cnt_r, 2'b00});
    end else if (any_s) begin
      mem_we = we_s & ~oor_s;
      mem_a  = addr_s;
      mem_wd = wdata_s;
    end else begin
      mem_we = 1'b0;
    end
  end

  // Clear sequencer: walk every word once, then hand the memory back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
      clr_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_cnt_r == AW'(DEPTH - 1)) begin
            state_r   <= ST_SERVE;
            clr_cnt_r <= '0;
          end else begin
            clr_cnt_r <= clr_cnt_r + AW'(32'd1);
          end
        end
        ST_SERVE: begin
          if (clr_start) begin
            state_r <= ST_CLEAR;
          end else begin
            state_r <= ST_SERVE;
          end
          clr_cnt_r <= '0;
        end
        default: begin
          state_r   <= ST_SERVE;
          clr_cnt_r <= '0;
        end
      endcase
    end
  end

  // Per-port response: read data and range error land one cycle after grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_r   <= 2'b00;
      err_r      <= 2'b00;
      rdata_r[0] <= 32'h0000_0000;
      rdata_r[1] <= 32'h0000_0000;
    end else begin
      for (int p = 0; p < 2; p++) begin
        rvalid_r[p] <= gnt_s[p] & ~we_s;
        err_r[p]    <= gnt_s[p] & oor_s;
        if (gnt_s[p] && !we_s) begin
          rdata_r[p] <= oor_s ? 32'h0000_0000 : mem_rd;
        end else begin
          rdata_r[p] <= rdata_r[p];
        end
      end
    end
  end

  assign clr_busy  = (state_r == ST_CLEAR);
  assign m0_gnt    = gnt_s[0];
  assign m1_gnt    = gnt_s[1];
  assign m0_rvalid = rvalid_r[0];
  assign m1_rvalid = rvalid_r[1];
  assign m0_err    = err_r[0];
  assign m1_err    = err_r[1];
  assign m0_rdata  = rdata_r[0];
  assign m1_rdata  = rdata_r[1];

endmodule
